// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with a one-entry skid buffer.
// The predictor's verdict on the held instruction steers the next fetch PC.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_i,
    input  logic        bp_isbranch_i,
    input  logic [31:0] bp_branch_addr_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o
);
    typedef enum logic [2:0] {S_REQ, S_WAIT, S_FULL, S_PRED, S_FLUSH} state_e;
    state_e      state_q;
    logic [31:0] pc_q, inst_q, addr_q, buf_inst_q, buf_addr_q, req_addr_q;
    logic        valid_q, buf_valid_q, consume;
    assign consume      = valid_q && !hold_i;
    assign ibus_req_o   = !rst && state_q == S_REQ;
    assign ibus_addr_o  = pc_q;
    assign inst_valid_o = valid_q;
    assign inst_o       = inst_q;
    assign inst_addr_o  = addr_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            valid_q     <= 1'b0;
            inst_q      <= NOP_INST;
            addr_q      <= 32'h0;
            buf_valid_q <= 1'b0;
            buf_inst_q  <= NOP_INST;
            buf_addr_q  <= 32'h0;
            req_addr_q  <= RESET_PC;
        end else if (jump_flag_i) begin
            pc_q        <= jump_addr_i;
            valid_q     <= 1'b0;
            inst_q      <= NOP_INST;
            addr_q      <= 32'h0;
            buf_valid_q <= 1'b0;
            case (state_q)
                S_REQ:   state_q <= ibus_gnt_i ? S_FLUSH : S_REQ;
                // A response still owed to the bus must be drained before refetching.
                S_WAIT:  state_q <= ibus_rvalid_i ? S_REQ : S_FLUSH;
                S_FLUSH: state_q <= ibus_rvalid_i ? S_REQ : S_FLUSH;
                default: state_q <= S_REQ;
            endcase
        end else begin
            if (consume) valid_q <= 1'b0;
            case (state_q)
                S_REQ: if (ibus_gnt_i) begin
                    req_addr_q <= pc_q;
                    state_q    <= S_WAIT;
                end
                S_WAIT: if (ibus_rvalid_i) begin
                    if (!valid_q || consume) begin
                        inst_q  <= ibus_rdata_i;
                        addr_q  <= req_addr_q;
                        valid_q <= 1'b1;
                        state_q <= S_PRED;
                    end else begin
                        buf_inst_q  <= ibus_rdata_i;
                        buf_addr_q  <= req_addr_q;
                        buf_valid_q <= 1'b1;
                        state_q     <= S_FULL;
                    end
                end
                S_FULL: if (buf_valid_q && consume) begin
                    inst_q      <= buf_inst_q;
                    addr_q      <= buf_addr_q;
                    valid_q     <= 1'b1;
                    buf_valid_q <= 1'b0;
                    state_q     <= S_PRED;
                end
                S_PRED: begin
                    pc_q    <= bp_isbranch_i ? bp_branch_addr_i : addr_q + 32'd4;
                    state_q <= S_REQ;
                end
                S_FLUSH: if (ibus_rvalid_i) state_q <= S_REQ;
                default: state_q <= S_REQ;
            endcase
        end
    end
endmodule
